regfile_arbiter: RTL and testbench
==================================

Name: regfile_arbiter

Overview:
- Sole owner of the register file's control pins: write enable, A/B indices, write data.
- Shares the single-write, dual-read register file between two requesters: port 0 is the CPU datapath, port 1 is the debug/loader.
- After reset, runs a zero-fill sequence over every register, then arbitrates round-robin.
- Sits between the control FSM/debug unit and the register file, one level above the ALU datapath.

Parameters:
- WIDTH, 16, data width of a register.
- REG_BITS, 5, index width; register count is 1<<REG_BITS.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  port 0 request; held high until gnt0.
- we0  input  1  port 0 write; otherwise a read.
- a_idx0  input  REG_BITS  port 0 A index; also the write index.
- b_idx0  input  REG_BITS  port 0 B index (reads only).
- wdata0  input  WIDTH  port 0 write data.
- gnt0  output  1  port 0 granted this cycle (combinational).
- rvalid0  output  1  port 0 read data valid (registered).
- rdata_a0  output  WIDTH  port 0 A read data.
- rdata_b0  output  WIDTH  port 0 B read data.
- req1, we1, a_idx1, b_idx1, wdata1, gnt1, rvalid1, rdata_a1, rdata_b1: same as port 0, for port 1.
- rf_reg_write  output  1  to register file write enable.
- rf_A_index  output  REG_BITS  to register file A index; this is also the write index.
- rf_B_index  output  REG_BITS  to register file B index.
- rf_write_data  output  WIDTH  to register file write data.
- rf_A_data  input  WIDTH  from register file, combinational read.
- rf_B_data  input  WIDTH  from register file, combinational read.
- init_done  output  1  high once zero-fill has completed.

Behaviour:
- States: INIT and ARB.
- Reset, asserted on a clock edge:
  - state=INIT, init counter=0, last_grant=1 (port 0 wins the first tie).
  - Registered outputs clear: rvalid0/1=0, rdata_*=0, init_done=0.
  - Reset mid-transaction discards any pending rvalid; no response is produced for it.
- INIT:
  - Each cycle: rf_reg_write=1, rf_A_index=counter, rf_write_data=0, rf_B_index=0; counter increments.
  - Lasts exactly 1<<REG_BITS cycles (indices 0..31 by default).
  - On the edge after index (1<<REG_BITS)-1 is written: state=ARB, init_done=1.
  - gnt0=gnt1=0 throughout; requests stay pending.
- ARB winner selection (combinational, same cycle):
  - Only one requester high: that port wins.
  - Both high: the port opposite last_grant wins.
  - Neither high: no grant; rf_reg_write=0, rf_A_index=0, rf_B_index=0, rf_write_data=0.
- Issue:
  - Winner's a_idx drives rf_A_index; b_idx drives rf_B_index; wdata drives rf_write_data.
  - rf_reg_write = winner's we AND (a_idx != 0). Writes to r0 are acknowledged but suppressed.
  - last_grant updates to the winner on the clock edge.
- Read response:
  - For a granted read, on that edge: rdata_aN<=rf_A_data, rdata_bN<=rf_B_data, rvalidN<=1.
  - rvalidN is a one-cycle pulse. rdata holds its value until the next read by the same port.
  - Latency: grant in cycle T, data valid in cycle T+1.
- Granted writes:
  - Committed at the edge closing the grant cycle.
  - A read of the same index granted in the next cycle returns the new value.
  - No rvalid pulse is produced for a write.
- Back-to-back requests:
  - A requester holding req gets at most every other slot while the other port also requests.
  - With a sole requester, it is granted every cycle (throughput 1/cycle).
- Registered outputs: rvalid*, rdata*, init_done, and internal state only. Grants and rf_* outputs are combinational from state/requests.

Test Plan:
- Reset then idle: rf_reg_write=1 for exactly 32 cycles with indices 0..31 and data 0. init_done rises on cycle 32. A req0 held during INIT gets no grant until init_done=1.
- Port 0 writes r5=0x1234. Next cycle port 0 reads a=5, b=0: gnt0 immediate; rvalid0 one cycle later with rdata_a0=0x1234, rdata_b0=0.
- req0 and req1 held high continuously with reads of r1/r2: grants alternate 0,1,0,1 starting with port 0. Each rvalid arrives one cycle after its grant.
- Port 1 writes r0=0xFFFF: gnt1=1 and rf_reg_write=0. A subsequent read of r0 returns 0.
- Sole requester port 1 issues 4 consecutive reads of r3: gnt1 is high 4 consecutive cycles and rvalid1 is high 4 consecutive cycles.
- Reset asserted the cycle after a read grant: rvalid stays 0, state returns to INIT, and the 32-cycle zero-fill restarts. The previously written r5 reads back as 0 afterwards.

Source files
------------

// File: rtl/regfile_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_arbiter
//  Description : Owns the register file control pins. After reset it zero-fills
//                every register, then shares the single-write / dual-read
//                register file between the CPU datapath (port 0) and the
//                debug/loader (port 1) with round-robin arbitration.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_arbiter #(
    parameter int WIDTH    = 16,
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    // port 0: CPU datapath
    input  logic                req0,
    input  logic                we0,
    input  logic [REG_BITS-1:0] a_idx0,
    input  logic [REG_BITS-1:0] b_idx0,
    input  logic [WIDTH-1:0]    wdata0,
    output logic                gnt0,
    output logic                rvalid0,
    output logic [WIDTH-1:0]    rdata_a0,
    output logic [WIDTH-1:0]    rdata_b0,
    // port 1: debug/loader
    input  logic                req1,
    input  logic                we1,
    input  logic [REG_BITS-1:0] a_idx1,
    input  logic [REG_BITS-1:0] b_idx1,
    input  logic [WIDTH-1:0]    wdata1,
    output logic                gnt1,
    output logic                rvalid1,
    output logic [WIDTH-1:0]    rdata_a1,
    output logic [WIDTH-1:0]    rdata_b1,
    // register file side
    output logic                rf_reg_write,
    output logic [REG_BITS-1:0] rf_A_index,
    output logic [REG_BITS-1:0] rf_B_index,
    output logic [WIDTH-1:0]    rf_write_data,
    input  logic [WIDTH-1:0]    rf_A_data,
    input  logic [WIDTH-1:0]    rf_B_data,
    output logic                init_done
);

    localparam logic [0:0]          c_st_init  = 1'b0;
    localparam logic [0:0]          c_st_arb   = 1'b1;
    localparam logic [REG_BITS-1:0] c_last_idx = '1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic [REG_BITS-1:0] r_cnt;
    logic                r_last_grant;   // 1: port 1 was granted last
    logic                w_sel0;
    logic                w_sel1;
    logic                r_rvalid0;
    logic                r_rvalid1;
    logic [WIDTH-1:0]    r_rdata_a0;
    logic [WIDTH-1:0]    r_rdata_b0;
    logic [WIDTH-1:0]    r_rdata_a1;
    logic [WIDTH-1:0]    r_rdata_b1;
    logic                r_init_done;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_init;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, winner selection and register-file control mux
    always_comb begin
        w_state_next  = r_state;
        w_sel0        = 1'b0;
        w_sel1        = 1'b0;
        rf_reg_write  = 1'b0;
        rf_A_index    = '0;
        rf_B_index    = '0;
        rf_write_data = '0;
        case (r_state)
            c_st_init: begin
                // zero-fill: one register per cycle, requests left pending
                rf_reg_write = 1'b1;
                rf_A_index   = r_cnt;
                if (r_cnt == c_last_idx) begin
                    w_state_next = c_st_arb;
                end
            end
            c_st_arb: begin
                // on a tie the port opposite the last grant wins
                w_sel0 = req0 & (~req1 | r_last_grant);
                w_sel1 = req1 & (~req0 | ~r_last_grant);
                if (w_sel0) begin
                    rf_A_index    = a_idx0;
                    rf_B_index    = b_idx0;
                    rf_write_data = wdata0;
                    rf_reg_write  = we0 & (a_idx0 != '0);
                end else if (w_sel1) begin
                    rf_A_index    = a_idx1;
                    rf_B_index    = b_idx1;
                    rf_write_data = wdata1;
                    rf_reg_write  = we1 & (a_idx1 != '0);
                end
            end
            default: begin
                w_state_next = c_st_init;
            end
        endcase
    end

    // Init counter, grant history and read-response capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_rvalid0    <= 1'b0;
            r_rvalid1    <= 1'b0;
            r_rdata_a0   <= '0;
            r_rdata_b0   <= '0;
            r_rdata_a1   <= '0;
            r_rdata_b1   <= '0;
            r_init_done  <= 1'b0;
        end else begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            if (r_state == c_st_init) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == c_last_idx) begin
                    r_init_done <= 1'b1;
                end
            end
            if (w_sel0) begin
                r_last_grant <= 1'b0;
                if (!we0) begin
                    r_rvalid0  <= 1'b1;
                    r_rdata_a0 <= rf_A_data;
                    r_rdata_b0 <= rf_B_data;
                end
            end
            if (w_sel1) begin
                r_last_grant <= 1'b1;
                if (!we1) begin
                    r_rvalid1  <= 1'b1;
                    r_rdata_a1 <= rf_A_data;
                    r_rdata_b1 <= rf_B_data;
                end
            end
        end
    end

    assign gnt0      = w_sel0;
    assign gnt1      = w_sel1;
    assign rvalid0   = r_rvalid0;
    assign rvalid1   = r_rvalid1;
    assign rdata_a0  = r_rdata_a0;
    assign rdata_b0  = r_rdata_b0;
    assign rdata_a1  = r_rdata_a1;
    assign rdata_b1  = r_rdata_b1;
    assign init_done = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_regfile_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_arbiter
//  Description : Self-checking bench for regfile_arbiter with a register-file
//                model, a table of directed vectors, reset/zero-fill sequences
//                and a randomized phase compared against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_arbiter;

    localparam int WIDTH    = 16;
    localparam int REG_BITS = 5;
    localparam int NREG     = 1 << REG_BITS;

    logic                clk;
    logic                reset;
    logic                req0, we0, req1, we1;
    logic [REG_BITS-1:0] a_idx0, b_idx0, a_idx1, b_idx1;
    logic [WIDTH-1:0]    wdata0, wdata1;
    logic                gnt0, gnt1, rvalid0, rvalid1;
    logic [WIDTH-1:0]    rdata_a0, rdata_b0, rdata_a1, rdata_b1;
    logic                rf_reg_write;
    logic [REG_BITS-1:0] rf_A_index, rf_B_index;
    logic [WIDTH-1:0]    rf_write_data, rf_A_data, rf_B_data;
    logic                init_done;

    regfile_arbiter #(.WIDTH(WIDTH), .REG_BITS(REG_BITS)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .a_idx0(a_idx0), .b_idx0(b_idx0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata_a0(rdata_a0), .rdata_b0(rdata_b0),
        .req1(req1), .we1(we1), .a_idx1(a_idx1), .b_idx1(b_idx1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata_a1(rdata_a1), .rdata_b1(rdata_b1),
        .rf_reg_write(rf_reg_write), .rf_A_index(rf_A_index), .rf_B_index(rf_B_index),
        .rf_write_data(rf_write_data), .rf_A_data(rf_A_data), .rf_B_data(rf_B_data),
        .init_done(init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical register file driven purely by the DUT's rf_* pins
    logic [WIDTH-1:0] rf_mem [NREG];
    assign rf_A_data = rf_mem[rf_A_index];
    assign rf_B_data = rf_mem[rf_B_index];
    always @(posedge clk) begin
        if (rf_reg_write) rf_mem[rf_A_index] <= rf_write_data;
    end

    // Reference model: architectural contents and expected responses
    logic [WIDTH-1:0] m_mem [NREG];
    int               m_last;
    bit               pend_rv [2];
    logic [WIDTH-1:0] pend_a [2], pend_b [2];
    logic [WIDTH-1:0] h_a [2], h_b [2];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_mem[i] = '0;
        m_last = 1;
        for (int p = 0; p < 2; p++) begin
            pend_rv[p] = 0; pend_a[p] = '0; pend_b[p] = '0; h_a[p] = '0; h_b[p] = '0;
        end
    endtask

    // Drive one request cycle and check the combinational outputs against the model
    task automatic apply(input bit r0, input bit w0, input logic [4:0] a0, input logic [4:0] b0,
                         input logic [15:0] d0, input bit r1, input bit w1, input logic [4:0] a1,
                         input logic [4:0] b1, input logic [15:0] d1);
        int win;
        bit ww;
        logic [4:0] wa, wb;
        logic [15:0] wd;
        req0 = r0; we0 = w0; a_idx0 = a0; b_idx0 = b0; wdata0 = d0;
        req1 = r1; we1 = w1; a_idx1 = a1; b_idx1 = b1; wdata1 = d1;
        #1;
        if (r0 && r1)  win = (m_last == 1) ? 0 : 1;
        else if (r0)   win = 0;
        else if (r1)   win = 1;
        else           win = -1;
        chk("gnt0", gnt0, win == 0);
        chk("gnt1", gnt1, win == 1);
        if (win < 0) begin
            chk("idle_we", rf_reg_write, 0);
            chk("idle_a", rf_A_index, 0);
            chk("idle_b", rf_B_index, 0);
            chk("idle_wd", rf_write_data, 0);
        end else begin
            ww = (win == 0) ? w0 : w1;
            wa = (win == 0) ? a0 : a1;
            wb = (win == 0) ? b0 : b1;
            wd = (win == 0) ? d0 : d1;
            chk("rf_we", rf_reg_write, ww && (wa != 0));
            chk("rf_a", rf_A_index, wa);
            chk("rf_b", rf_B_index, wb);
            chk("rf_wd", rf_write_data, wd);
            if (!ww) begin
                pend_rv[win] = 1;
                pend_a[win]  = m_mem[wa];
                pend_b[win]  = m_mem[wb];
            end else if (wa != 0) begin
                m_mem[wa] = wd;
            end
            m_last = win;
        end
    endtask

    // Advance one edge and check the registered responses
    task automatic clk_resp();
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (pend_rv[p]) begin
                h_a[p] = pend_a[p];
                h_b[p] = pend_b[p];
            end
        end
        chk("rvalid0", rvalid0, pend_rv[0]);
        chk("rvalid1", rvalid1, pend_rv[1]);
        chk("rdata_a0", rdata_a0, h_a[0]);
        chk("rdata_b0", rdata_b0, h_b[0]);
        chk("rdata_a1", rdata_a1, h_a[1]);
        chk("rdata_b1", rdata_b1, h_b[1]);
        pend_rv[0] = 0;
        pend_rv[1] = 0;
    endtask

    // Zero-fill walk: entered just after the reset edge, requests as currently driven
    task automatic init_walk();
        for (int i = 0; i < NREG; i++) begin
            #1;
            chk("init_we", rf_reg_write, 1);
            chk("init_a", rf_A_index, i);
            chk("init_b", rf_B_index, 0);
            chk("init_wd", rf_write_data, 0);
            chk("init_gnt0", gnt0, 0);
            chk("init_gnt1", gnt1, 0);
            chk("init_done_lo", init_done, 0);
            @(posedge clk);
            #1;
        end
        chk("init_done_hi", init_done, 1);
        for (int i = 0; i < NREG; i++) chk("zero_fill", rf_mem[i], 0);
    endtask

    typedef struct {
        bit          r0, w0;
        logic [4:0]  a0, b0;
        logic [15:0] d0;
        bit          r1, w1;
        logic [4:0]  a1, b1;
        logic [15:0] d1;
        bit          eg0, eg1, ewe;
        logic [1:0]  erv;
        logic [15:0] era;
    } vec_t;

    function automatic vec_t mk(bit r0, bit w0, logic [4:0] a0, logic [4:0] b0, logic [15:0] d0,
                                bit r1, bit w1, logic [4:0] a1, logic [4:0] b1, logic [15:0] d1,
                                bit eg0, bit eg1, bit ewe, logic [1:0] erv, logic [15:0] era);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.b0 = b0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.b1 = b1; v.d1 = d1;
        v.eg0 = eg0; v.eg1 = eg1; v.ewe = ewe; v.erv = erv; v.era = era;
        return v;
    endfunction

    vec_t tbl [15];

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // both read r1/r2 -> alternate starting with port 0
        tbl[0]  = mk(1,0,1,2,16'h0,    1,0,2,1,16'h0,    1,0,0, 2'b01, 16'h0);
        tbl[1]  = mk(1,0,1,2,16'h0,    1,0,2,1,16'h0,    0,1,0, 2'b10, 16'h0);
        tbl[2]  = mk(1,0,1,2,16'h0,    1,0,2,1,16'h0,    1,0,0, 2'b01, 16'h0);
        tbl[3]  = mk(1,0,1,2,16'h0,    1,0,2,1,16'h0,    0,1,0, 2'b10, 16'h0);
        // port 0 writes r5 then reads it back the next cycle
        tbl[4]  = mk(1,1,5,0,16'h1234, 0,0,0,0,16'h0,    1,0,1, 2'b00, 16'h0);
        tbl[5]  = mk(1,0,5,0,16'h0,    0,0,0,0,16'h0,    1,0,0, 2'b01, 16'h1234);
        // port 1 write to r0 is acknowledged but suppressed
        tbl[6]  = mk(0,0,0,0,16'h0,    1,1,0,0,16'hFFFF, 0,1,0, 2'b00, 16'h0);
        tbl[7]  = mk(0,0,0,0,16'h0,    1,0,0,0,16'h0,    0,1,0, 2'b10, 16'h0);
        // sole requester: back-to-back reads
        tbl[8]  = mk(0,0,0,0,16'h0,    1,0,3,3,16'h0,    0,1,0, 2'b10, 16'h0);
        tbl[9]  = mk(0,0,0,0,16'h0,    1,0,3,3,16'h0,    0,1,0, 2'b10, 16'h0);
        tbl[10] = mk(0,0,0,0,16'h0,    1,0,3,3,16'h0,    0,1,0, 2'b10, 16'h0);
        tbl[11] = mk(0,0,0,0,16'h0,    1,0,3,3,16'h0,    0,1,0, 2'b10, 16'h0);
        // idle, then contended writes and contended reads
        tbl[12] = mk(0,0,0,0,16'h0,    0,0,0,0,16'h0,    0,0,0, 2'b00, 16'h0);
        tbl[13] = mk(1,1,7,0,16'h00AA, 1,1,8,0,16'h00BB, 1,0,1, 2'b00, 16'h0);
        tbl[14] = mk(1,0,8,7,16'h0,    1,0,7,8,16'h0,    0,1,0, 2'b10, 16'h00AA);

        for (int i = 0; i < NREG; i++) rf_mem[i] = WIDTH'($urandom);
        model_reset();
        reset = 1'b1;
        req0 = 0; we0 = 0; a_idx0 = '0; b_idx0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; a_idx1 = '0; b_idx1 = '0; wdata1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_rvalid1", rvalid1, 0);
        chk("rst_rdata_a0", rdata_a0, 0);
        chk("rst_rdata_b1", rdata_b1, 0);
        chk("rst_init_done", init_done, 0);

        // both ports hold read requests through the zero-fill
        reset = 1'b0;
        req0 = 1; a_idx0 = 5'd1; b_idx0 = 5'd2;
        req1 = 1; a_idx1 = 5'd2; b_idx1 = 5'd1;
        init_walk();

        // directed table
        for (int i = 0; i < 15; i++) begin
            apply(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].b0, tbl[i].d0,
                  tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].b1, tbl[i].d1);
            chk("tbl_gnt0", gnt0, tbl[i].eg0);
            chk("tbl_gnt1", gnt1, tbl[i].eg1);
            chk("tbl_we", rf_reg_write, tbl[i].ewe);
            clk_resp();
            chk("tbl_rvalid0", rvalid0, tbl[i].erv[0]);
            chk("tbl_rvalid1", rvalid1, tbl[i].erv[1]);
            if (tbl[i].erv[0]) chk("tbl_rdata_a0", rdata_a0, tbl[i].era);
            if (tbl[i].erv[1]) chk("tbl_rdata_a1", rdata_a1, tbl[i].era);
        end

        // reset while a read is granted: response dropped, zero-fill restarts
        apply(1,1,5,0,16'h5A5A, 0,0,0,0,16'h0);
        clk_resp();
        reset = 1'b1;
        apply(1,0,5,0,16'h0, 0,0,0,0,16'h0);
        @(posedge clk);
        #1;
        chk("midrst_rvalid0", rvalid0, 0);
        chk("midrst_rdata_a0", rdata_a0, 0);
        chk("midrst_init_done", init_done, 0);
        model_reset();
        reset = 1'b0;
        req0 = 0; req1 = 0;
        init_walk();
        apply(1,0,5,0,16'h0, 0,0,0,0,16'h0);
        clk_resp();
        chk("r5_after_reset", rdata_a0, 0);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            apply(1'($urandom), 1'($urandom), 5'($urandom_range(0,7)), 5'($urandom_range(0,7)),
                  16'($urandom),
                  1'($urandom), 1'($urandom), 5'($urandom_range(0,7)), 5'($urandom_range(0,7)),
                  16'($urandom));
            clk_resp();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
